// File: rtl/hpu_reset_seq_pkg.sv
// Shared types and constants for the HPU soft-reset sequencer.
package hpu_reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    DONE,
    ERROR,
    WAIT_LOW
  } state_t;

  localparam logic ERR_PHASE_ENTER   = 1'b0;
  localparam logic ERR_PHASE_RELEASE = 1'b1;

endpackage

// File: rtl/hpu_reset_seq_if.sv
// Handshake bundle between the config register block, the reset sequencer and the sub-domains.
interface hpu_reset_seq_if #(
  parameter int DOM_NB = 4,
  parameter int DOM_W  = (DOM_NB > 1) ? $clog2(DOM_NB) : 1
);

  logic              reset_req;
  logic              reset_done;
  logic              busy;
  logic              error;
  logic [DOM_W-1:0]  err_dom;
  logic              err_phase;
  logic [DOM_NB-1:0] dom_srst;
  logic [DOM_NB-1:0] dom_in_rst;
  logic [DOM_NB-1:0] dom_ready;

  modport master (
    input  reset_req, dom_in_rst, dom_ready,
    output reset_done, busy, error, err_dom, err_phase, dom_srst
  );

  modport slave (
    output reset_req, dom_in_rst, dom_ready,
    input  reset_done, busy, error, err_dom, err_phase, dom_srst
  );

endinterface

// File: rtl/hpu_reset_seq_timer.sv
// Saturating up-counter shared by the hold window and the per-step timeout.
module hpu_reset_seq_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/hpu_reset_sequencer.sv
// Asserts all sub-domain soft resets together, holds them, then releases them in index order,
// waiting for each domain to report ready before moving to the next.
module hpu_reset_sequencer
  import hpu_reset_seq_pkg::*;
#(
  parameter int DOM_NB      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic            cfg_clk,
  input  logic            cfg_srst,
  hpu_reset_seq_if.master bus
);

  localparam int DOM_W   = (DOM_NB > 1) ? $clog2(DOM_NB) : 1;
  localparam int CNT_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [DOM_W-1:0] LAST_IDX = DOM_W'(DOM_NB - 1);

  state_t            state, state_nx;
  logic [DOM_W-1:0]  idx, idx_nx;
  logic [DOM_NB-1:0] srst, srst_nx;
  logic              done, done_nx;
  logic              busy, busy_nx;
  logic              err, err_nx;
  logic [DOM_W-1:0]  edom, edom_nx;
  logic              eph, eph_nx;
  logic              tmr_clear, tmr_en, tmr_hit;
  logic [CNT_W-1:0]  tmr_limit;

  function automatic logic [DOM_W-1:0] first_low(input logic [DOM_NB-1:0] v);
    logic [DOM_W-1:0] r;
    r = '0;
    for (int i = DOM_NB - 1; i >= 0; i--) begin
      if (!v[i]) r = DOM_W'(i);
    end
    return r;
  endfunction

  hpu_reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (cfg_clk),
    .rst    (cfg_srst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .hit    (tmr_hit)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    srst_nx  = srst;
    done_nx  = 1'b0;
    err_nx   = err;
    edom_nx  = edom;
    eph_nx   = eph;
    unique case (state)
      IDLE: begin
        if (bus.reset_req) begin
          state_nx = ASSERT;
          err_nx   = 1'b0;
          srst_nx  = '1;
          idx_nx   = '0;
        end
      end
      ASSERT: begin
        if (&bus.dom_in_rst) begin
          state_nx = HOLD;
        end else if (tmr_hit) begin
          state_nx = ERROR;
          err_nx   = 1'b1;
          eph_nx   = ERR_PHASE_ENTER;
          edom_nx  = first_low(bus.dom_in_rst);
          srst_nx  = '0;
          done_nx  = 1'b1;
        end
      end
      HOLD: begin
        if (tmr_hit) begin
          state_nx   = RELEASE;
          srst_nx[0] = 1'b0;
        end
      end
      RELEASE: begin
        // Ready is checked before the timeout so a same-cycle arrival still counts as success.
        if (bus.dom_ready[idx]) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            idx_nx          = idx + DOM_W'(1);
            srst_nx[idx_nx] = 1'b0;
          end
        end else if (tmr_hit) begin
          state_nx = ERROR;
          err_nx   = 1'b1;
          eph_nx   = ERR_PHASE_RELEASE;
          edom_nx  = idx;
          srst_nx  = '0;
          done_nx  = 1'b1;
        end
      end
      DONE:     state_nx = WAIT_LOW;
      ERROR:    state_nx = WAIT_LOW;
      WAIT_LOW: if (!bus.reset_req) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase

    busy_nx   = state_nx inside {ASSERT, HOLD, RELEASE, DONE, ERROR};
    tmr_en    = state inside {ASSERT, HOLD, RELEASE};
    tmr_clear = (state_nx != state) || (idx_nx != idx);
    tmr_limit = (state == HOLD) ? CNT_W'(HOLD_CYCLES) : CNT_W'(TIMEOUT);
  end

  always_ff @(posedge cfg_clk) begin
    if (cfg_srst) begin
      state <= IDLE;
      idx   <= '0;
      srst  <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      edom  <= '0;
      eph   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      srst  <= srst_nx;
      done  <= done_nx;
      busy  <= busy_nx;
      err   <= err_nx;
      edom  <= edom_nx;
      eph   <= eph_nx;
    end
  end

  assign bus.dom_srst   = srst;
  assign bus.reset_done = done;
  assign bus.busy       = busy;
  assign bus.error      = err;
  assign bus.err_dom    = edom;
  assign bus.err_phase  = eph;

endmodule
